// File: rtl/binary_tree_mcast_pipe_if.sv
// Source-side and output-side bus of the multicast tree: per-source valid/data/mask in,
// per-output valid/data plus granted masks and conflict status out.
interface binary_tree_mcast_pipe_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 8,
    parameter int NUM_OUTPUT_DATA = 8,
    parameter int CNT_WIDTH       = 16
);
    logic                                    i_en;
    logic                                    i_out_ready;
    logic                                    i_ready;
    logic [NUM_INPUT_DATA-1:0]               i_valid;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]    i_data_bus;
    logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_cmd;
    logic                                    i_clr_err;
    logic [NUM_OUTPUT_DATA-1:0]              o_valid;
    logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0]   o_data_bus;
    logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd;
    logic                                    o_conflict;
    logic [CNT_WIDTH-1:0]                    o_conflict_cnt;

    modport slave (
        input  i_en, i_out_ready, i_valid, i_data_bus, i_cmd, i_clr_err,
        output i_ready, o_valid, o_data_bus, o_cmd, o_conflict, o_conflict_cnt
    );

    modport master (
        output i_en, i_out_ready, i_valid, i_data_bus, i_cmd, i_clr_err,
        input  i_ready, o_valid, o_data_bus, o_cmd, o_conflict, o_conflict_cnt
    );
endinterface

// File: rtl/binary_tree_mcast_pipe.sv
// Pipelined multicast network: fixed-priority ingress arbitration, then one registered
// binary tree per source (one stage per level), OR-merged onto the shared output ports.

// One source's tree. Nodes are kept in heap order: node i has children 2i+1 / 2i+2,
// and the leaves (level LVL) occupy the top NUM_OUTPUT_DATA entries.
module binary_tree_mcast_lane #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUT_DATA = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          adv_i,
    input  logic                                          vld_i,
    input  logic [DATA_WIDTH-1:0]                         data_i,
    input  logic [NUM_OUTPUT_DATA-1:0]                    grant_i,
    output logic [NUM_OUTPUT_DATA-1:0]                    leaf_vld_o,
    output logic [NUM_OUTPUT_DATA-1:0][DATA_WIDTH-1:0]    leaf_data_o,
    output logic [NUM_OUTPUT_DATA-1:0]                    grant_o
);
    localparam int LVL   = $clog2(NUM_OUTPUT_DATA);
    localparam int NODES = 2*NUM_OUTPUT_DATA - 1;

    logic [NODES-1:0]                  vld_q;
    logic [NODES-1:0][DATA_WIDTH-1:0]  data_q;
    logic [LVL:0][NUM_OUTPUT_DATA-1:0] grant_q;
    logic [NODES-1:1]                  fwd;

    // The grant copy at stage l-1 is aligned with the level l-1 parents, so each node
    // checks its own leaf range of that copy instead of storing a shrinking sub-mask.
    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
        for (genvar p = 0; p < (1 << l); p++) begin : g_node
            localparam int I = (1 << l) - 1 + p;
            localparam int W = NUM_OUTPUT_DATA >> l;
            assign fwd[I] = vld_q[(I-1)/2] & (|grant_q[l-1][p*W +: W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else if (adv_i) begin
            vld_q[0]   <= vld_i;
            grant_q[0] <= grant_i;
            if (vld_i) data_q[0] <= data_i;
            for (int l = 1; l <= LVL; l++) grant_q[l] <= grant_q[l-1];
            // Unforwarded children drop valid but keep their data to avoid toggling.
            for (int i = 1; i < NODES; i++) begin
                vld_q[i] <= fwd[i];
                if (fwd[i]) data_q[i] <= data_q[(i-1)/2];
            end
        end
    end

    assign leaf_vld_o  = vld_q[NODES-1 -: NUM_OUTPUT_DATA];
    assign leaf_data_o = data_q[NODES-1 -: NUM_OUTPUT_DATA];
    assign grant_o     = grant_q[LVL];
endmodule

module binary_tree_mcast_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 8,
    parameter int NUM_OUTPUT_DATA = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    binary_tree_mcast_pipe_if.slave    bus
);
    localparam int DW = DATA_WIDTH;
    localparam int NI = NUM_INPUT_DATA;
    localparam int NO = NUM_OUTPUT_DATA;

    logic [1:0]                  rst_sync_q;
    logic                        rst_int_n;
    logic                        adv;
    logic [NI-1:0][NO-1:0]       eff, grant, grant_out, leaf_vld;
    logic [NI-1:0][NO-1:0][DW-1:0] leaf_data;
    logic [NO-1:0]               claimed, o_valid_d;
    logic [NO-1:0][DW-1:0]       o_data_d;
    logic                        conflict;
    logic                        conflict_q;
    logic [CNT_WIDTH-1:0]        cnt_q;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign adv         = bus.i_en & bus.i_out_ready;
    assign bus.i_ready = adv;

    // Lowest source index wins each output; anything a lower source already claimed is lost.
    always_comb begin
        eff      = '0;
        grant    = '0;
        claimed  = '0;
        conflict = 1'b0;
        for (int k = 0; k < NI; k++) begin
            eff[k]   = bus.i_cmd[k*NO +: NO] & {NO{bus.i_valid[k]}};
            grant[k] = eff[k] & ~claimed;
            conflict = conflict | (|(eff[k] & claimed));
            claimed  = claimed | eff[k];
        end
    end

    for (genvar k = 0; k < NI; k++) begin : g_lane
        binary_tree_mcast_lane #(
            .DATA_WIDTH      (DW),
            .NUM_OUTPUT_DATA (NO)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_int_n),
            .adv_i       (adv),
            .vld_i       (|grant[k]),
            .data_i      (bus.i_data_bus[k*DW +: DW]),
            .grant_i     (grant[k]),
            .leaf_vld_o  (leaf_vld[k]),
            .leaf_data_o (leaf_data[k]),
            .grant_o     (grant_out[k])
        );
    end

    // Grants are disjoint per output, so a plain OR of the masked leaves is the mux.
    always_comb begin
        o_valid_d = '0;
        o_data_d  = '0;
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < NO; j++) begin
                o_valid_d[j] = o_valid_d[j] | leaf_vld[k][j];
                o_data_d[j]  = o_data_d[j] | (leaf_data[k][j] & {DW{leaf_vld[k][j]}});
            end
        end
    end

    assign bus.o_valid    = o_valid_d;
    assign bus.o_data_bus = o_data_d;
    assign bus.o_cmd      = grant_out;

    // A conflict in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else if (adv && conflict) begin
            conflict_q <= 1'b1;
            if (bus.i_clr_err)  cnt_q <= CNT_WIDTH'(1);
            else if (!(&cnt_q)) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end else if (bus.i_clr_err) begin
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end
    end

    assign bus.o_conflict     = conflict_q;
    assign bus.o_conflict_cnt = cnt_q;
endmodule

// File: tb/tb_binary_tree_mcast_pipe.sv
// Directed bench for binary_tree_mcast_pipe: vector table plus stall, reset and
// counter-saturation sequences.
module tb_binary_tree_mcast_pipe;
    localparam int DW = 32, NI = 8, NO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_tree_mcast_pipe_if #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO), .CNT_WIDTH(16)) bus ();
    binary_tree_mcast_pipe_if #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO), .CNT_WIDTH(2))  sbus ();

    binary_tree_mcast_pipe #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO), .CNT_WIDTH(16))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    binary_tree_mcast_pipe #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO), .CNT_WIDTH(2))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

    typedef struct {
        logic [7:0]   valid;
        logic [63:0]  cmd;
        logic         clr;
        logic [7:0]   ov;
        logic [255:0] d;
        logic [63:0]  ocmd;
        logic         conf;
        logic [15:0]  cnt;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] valid, input logic [63:0] cmd, input logic clr,
                                input logic [7:0] ov, input logic [255:0] d, input logic [63:0] ocmd,
                                input logic conf, input logic [15:0] cnt);
        vec_t v;
        v.valid = valid; v.cmd = cmd; v.clr = clr; v.ov = ov;
        v.d = d; v.ocmd = ocmd; v.conf = conf; v.cnt = cnt;
        return v;
    endfunction

    task automatic set_data();
        logic [3:0] nib;
        for (int k = 0; k < NI; k++) begin
            nib = 4'(8 + k);
            bus.i_data_bus[k*DW +: DW] = {8{nib}};
        end
    endtask

    task automatic drive(input logic [7:0] valid, input logic [63:0] cmd, input logic clr);
        bus.i_valid = valid; bus.i_cmd = cmd; bus.i_clr_err = clr;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ov, input logic [255:0] d,
                           input logic [63:0] ocmd, input logic conf, input logic [15:0] cnt);
        chk({tag, "_ov"},   bus.o_valid, ov);
        chk({tag, "_data"}, bus.o_data_bus, d);
        chk({tag, "_cmd"},  bus.o_cmd, ocmd);
        chk({tag, "_conf"}, bus.o_conflict, conf);
        chk({tag, "_cnt"},  bus.o_conflict_cnt, cnt);
    endtask

    initial begin
        int inj[0:40];
        int nadv, b, e, lat;
        logic rdy;
        logic [NO*DW-1:0] ed;
        logic [7:0] eov;

        vecs[0]  = mk(8'hFF, 64'h9020_4400_0000_0000, 1'b0, 8'hF4,
                      {32'hFFFFFFFF, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF, 32'h0, 32'hDDDDDDDD, 32'h0, 32'h0},
                      64'h9020_4400_0000_0000, 1'b0, 16'd0);
        vecs[1]  = mk(8'hFF, 64'h0020_2200_0000_0000, 1'b0, 8'h22,
                      {32'h0, 32'h0, 32'hDDDDDDDD, 32'h0, 32'h0, 32'h0, 32'hDDDDDDDD, 32'h0},
                      64'h0000_2200_0000_0000, 1'b1, 16'd1);
        vecs[2]  = mk(8'hFF, 64'h0020_2200_0000_0000, 1'b0, 8'h22,
                      {32'h0, 32'h0, 32'hDDDDDDDD, 32'h0, 32'h0, 32'h0, 32'hDDDDDDDD, 32'h0},
                      64'h0000_2200_0000_0000, 1'b1, 16'd2);
        vecs[3]  = mk(8'h00, 64'h0, 1'b1, 8'h00, 256'h0, 64'h0, 1'b0, 16'd0);
        vecs[4]  = mk(8'h7F, 64'h8000_0000_0000_0000, 1'b0, 8'h00, 256'h0, 64'h0, 1'b0, 16'd0);
        vecs[5]  = mk(8'hFF, 64'h8040_2010_0804_0201, 1'b0, 8'hFF,
                      {32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC,
                       32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999, 32'h88888888},
                      64'h8040_2010_0804_0201, 1'b0, 16'd0);
        vecs[6]  = mk(8'h01, {64{1'b1}}, 1'b0, 8'hFF, {8{32'h88888888}}, 64'hFF, 1'b0, 16'd0);
        vecs[7]  = mk(8'h03, 64'h0101, 1'b0, 8'h01, {224'h0, 32'h88888888}, 64'h01, 1'b1, 16'd1);
        vecs[8]  = mk(8'h03, 64'h0101, 1'b1, 8'h01, {224'h0, 32'h88888888}, 64'h01, 1'b1, 16'd1);
        vecs[9]  = mk(8'h00, 64'h0, 1'b1, 8'h00, 256'h0, 64'h0, 1'b0, 16'd0);
        vecs[10] = mk(8'h08, 64'h0, 1'b0, 8'h00, 256'h0, 64'h0, 1'b0, 16'd0);

        bus.i_en = 1'b1; bus.i_out_ready = 1'b1;
        drive(8'h00, 64'h0, 1'b0);
        set_data();
        sbus.i_en = 1'b1; sbus.i_out_ready = 1'b1; sbus.i_valid = '0;
        sbus.i_data_bus = '0; sbus.i_cmd = '0; sbus.i_clr_err = 1'b0;

        repeat (3) @(posedge clk);
        #1 chk_all("reset", 8'h00, 256'h0, 64'h0, 1'b0, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int m = 0; m < 4; m++) begin
            bus.i_en = m[0]; bus.i_out_ready = m[1]; bus.i_valid = 8'(m * 37 + 1);
            #1 chk($sformatf("ready_%0d", m), bus.i_ready, m[0] & m[1]);
        end
        bus.i_en = 1'b1; bus.i_out_ready = 1'b1;
        drive(8'h00, 64'h0, 1'b0);

        // Each vector: one input beat, three idle beats, result visible after the 4th edge.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].cmd, vecs[i].clr);
            @(posedge clk); #1;
            drive(8'h00, 64'h0, 1'b0);
            repeat (2) @(posedge clk);
            #1 chk($sformatf("v%0d_early", i), bus.o_valid, 8'h00);
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), vecs[i].ov, vecs[i].d, vecs[i].ocmd, vecs[i].conf, vecs[i].cnt);
        end

        // Backpressure: 6 unicast beats from source 0, 3-cycle stall with junk on the inputs.
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i <= 40; i++) inj[i] = -1;
        nadv = 0; b = 0;
        for (int t = 0; t < 20; t++) begin
            rdy = !(t >= 4 && t < 7);
            bus.i_out_ready = rdy;
            if (!rdy) drive(8'hFF, {64{1'b1}}, 1'b0);
            else if (b < 6) begin
                drive(8'h01, 64'(1) << b, 1'b0);
                bus.i_data_bus[0 +: DW] = 32'hA000_0000 + 32'(b);
            end else drive(8'h00, 64'h0, 1'b0);
            @(posedge clk); #1;
            if (rdy) begin
                nadv++;
                inj[nadv] = (b < 6) ? b : -1;
                if (b < 6) b++;
            end
            e = nadv - 3;
            ed = '0; eov = '0;
            if (e >= 1 && inj[e] >= 0) begin
                eov = 8'(1) << inj[e];
                ed[inj[e]*DW +: DW] = 32'hA000_0000 + 32'(inj[e]);
            end
            chk($sformatf("bp%0d_ov", t), bus.o_valid, eov);
            chk($sformatf("bp%0d_data", t), bus.o_data_bus, ed);
        end
        chk("bp_beats_sent", b, 6);
        chk("bp_no_conf", bus.o_conflict, 1'b0);
        bus.i_out_ready = 1'b1;
        drive(8'h00, 64'h0, 1'b0);
        set_data();

        // Async reset while a multicast beat is at the outputs and a conflict beat is in flight.
        drive(8'hFF, 64'h9020_4400_0000_0000, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk("rst_pre_ov", bus.o_valid, 8'hF4);
        drive(8'hFF, 64'h0020_2200_0000_0000, 1'b0);
        @(posedge clk); #1;
        chk("rst_pre_conf", bus.o_conflict, 1'b1);
        drive(8'h00, 64'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_all("rst_async", 8'h00, 256'h0, 64'h0, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_flushed", bus.o_valid, 8'h00);
        drive(8'h01, 64'h01, 1'b0);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(8'h00, 64'h0, 1'b0);
            if (bus.o_valid != 8'h00) begin
                lat = c;
                break;
            end
        end
        chk("rst_latency", lat, 4);
        chk("rst_out0", bus.o_data_bus[0 +: DW], 32'h88888888);

        // 2-bit counter saturates at 3 after five conflict cycles.
        sbus.i_valid = 8'h03; sbus.i_cmd = 64'h0101;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            chk($sformatf("sat_cnt%0d", n), sbus.o_conflict_cnt, (n < 3) ? n : 3);
        end
        sbus.i_valid = 8'h00; sbus.i_cmd = 64'h0;
        repeat (2) @(posedge clk);
        #1 chk("sat_hold", sbus.o_conflict_cnt, 2'd3);
        chk("sat_conf", sbus.o_conflict, 1'b1);
        sbus.i_clr_err = 1'b1;
        @(posedge clk); #1;
        sbus.i_clr_err = 1'b0;
        chk("sat_clr_cnt", sbus.o_conflict_cnt, 2'd0);
        chk("sat_clr_conf", sbus.o_conflict, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
